ppu_vram_ctr: RTL

- Scroll/VRAM address counter and background tile-fetch sequencer.
- Sits directly downstream of the PPU register interface and consumes its outputs: scroll latches, upd_cntrs, inc_addr, inc_addr_amt, bg_en.
- Owns the live PPU address counters and drives the VRAM address for both CPU 0x2007 accesses and rendering fetches.
- Delivers one assembled background tile (pattern lo/hi plus attribute) per 8 pixels to the pixel shifter.

---
 rtl/ppu_vram_ctr.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ppu_vram_ctr.sv
// Scroll/VRAM address counters and background tile-fetch sequencer for the PPU.
// Optional macro PPU_VRAM_INC_GLITCH_EN: a 0x2007 access while rendering bumps coarse X and Y.
module ppu_vram_ctr #(
  parameter int VIS_LINES = 240,
  parameter int PRE_LINE  = 261
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [2:0]  fv_in,
  input  logic [4:0]  vt_in,
  input  logic        v_in,
  input  logic [4:0]  ht_in,
  input  logic        h_in,
  input  logic        s_in,
  input  logic        upd_cntrs_in,
  input  logic        inc_addr_in,
  input  logic        inc_addr_amt_in,
  input  logic        bg_en_in,
  input  logic [9:0]  nes_x_in,
  input  logic [9:0]  nes_y_in,
  input  logic        pix_pulse_in,
  input  logic [7:0]  vram_d_in,
  output logic [13:0] vram_a_out,
  output logic [7:0]  bg_pat_lo_out,
  output logic [7:0]  bg_pat_hi_out,
  output logic [1:0]  bg_attr_out,
  output logic        bg_tile_vld_out,
  output logic        rendering_out
);

  localparam logic [9:0] VIS_Y = 10'(VIS_LINES);
  localparam logic [9:0] PRE_Y = 10'(PRE_LINE);

  typedef enum logic [1:0] {F_IDLE, F_NT, F_AT, F_LO} fetch_t;

  logic [2:0]  c_fv_r, fv_nxt_s;
  logic [4:0]  c_vt_r, vt_nxt_s;
  logic        c_v_r, v_nxt_s;
  logic        c_h_r, h_nxt_s;
  logic [4:0]  c_ht_r, ht_nxt_s;
  logic [14:0] cnt_s;
  logic [7:0]  nt_byte_r, pat_lo_r;
  logic [1:0]  at_bits_r, at_sel_s;
  fetch_t      fetch_r;
  logic [13:0] vram_a_r, addr_s;
  logic [7:0]  bg_pat_lo_r, bg_pat_hi_r;
  logic [1:0]  bg_attr_r;
  logic        tile_vld_r, rendering_r;
  logic        render_s, window_s, fetch_act_s, tile_end_s, glitch_s;
  logic        coarse_x_s, y_step_s, hreload_s, vreload_s;
  logic [2:0]  phase_s;

  // Vertical step of the scroll position; returns {fv, v, vt}.
  function automatic logic [8:0] y_inc(input logic [2:0] fv, input logic v, input logic [4:0] vt);
    logic [2:0] fv_o;
    logic       v_o;
    logic [4:0] vt_o;
    fv_o = fv + 3'd1;
    v_o  = v;
    vt_o = vt;
    if (fv == 3'd7) begin
      if (vt == 5'd29) begin
        vt_o = 5'd0;
        v_o  = ~v;
      end else if (vt == 5'd31) begin
        vt_o = 5'd0;
      end else begin
        vt_o = vt + 5'd1;
      end
    end else begin
      vt_o = vt;
    end
    return {fv_o, v_o, vt_o};
  endfunction

  assign cnt_s       = {c_fv_r, c_v_r, c_h_r, c_vt_r, c_ht_r};
  assign render_s    = bg_en_in && ((nes_y_in < VIS_Y) || (nes_y_in == PRE_Y));
  assign window_s    = (nes_x_in <= 10'd255) || ((nes_x_in >= 10'd320) && (nes_x_in <= 10'd335));
  assign phase_s     = nes_x_in[2:0];
  assign fetch_act_s = render_s && window_s;
  assign tile_end_s  = fetch_act_s && pix_pulse_in && (phase_s == 3'd7);

`ifdef PPU_VRAM_INC_GLITCH_EN
  assign glitch_s = render_s && inc_addr_in;
`else
  assign glitch_s = 1'b0;
`endif

  assign coarse_x_s = tile_end_s || glitch_s;
  assign y_step_s   = (pix_pulse_in && (nes_x_in == 10'd255)) || glitch_s;
  assign hreload_s  = pix_pulse_in && (nes_x_in == 10'd257);
  assign vreload_s  = pix_pulse_in && (nes_y_in == PRE_Y) && (nes_x_in == 10'd304);

  // Next counter values: latch load beats render updates, CPU increment only when idle.
  always_comb begin
    {fv_nxt_s, v_nxt_s, h_nxt_s, vt_nxt_s, ht_nxt_s} = cnt_s;
    if (upd_cntrs_in) begin
      {fv_nxt_s, v_nxt_s, h_nxt_s, vt_nxt_s, ht_nxt_s} = {fv_in, v_in, h_in, vt_in, ht_in};
    end else if (render_s) begin
      if (hreload_s) begin
        {h_nxt_s, ht_nxt_s} = {h_in, ht_in};
      end else if (coarse_x_s) begin
        {h_nxt_s, ht_nxt_s} = {c_h_r, c_ht_r} + 6'd1;
      end else begin
        {h_nxt_s, ht_nxt_s} = {c_h_r, c_ht_r};
      end
      if (vreload_s) begin
        {fv_nxt_s, v_nxt_s, vt_nxt_s} = {fv_in, v_in, vt_in};
      end else if (y_step_s) begin
        {fv_nxt_s, v_nxt_s, vt_nxt_s} = y_inc(c_fv_r, c_v_r, c_vt_r);
      end else begin
        {fv_nxt_s, v_nxt_s, vt_nxt_s} = {c_fv_r, c_v_r, c_vt_r};
      end
    end else if (inc_addr_in) begin
      {fv_nxt_s, v_nxt_s, h_nxt_s, vt_nxt_s, ht_nxt_s} = cnt_s + (inc_addr_amt_in ? 15'd32 : 15'd1);
    end else begin
      {fv_nxt_s, v_nxt_s, h_nxt_s, vt_nxt_s, ht_nxt_s} = cnt_s;
    end
  end

  // VRAM address: fetch address during the fetch window, live counters otherwise.
  always_comb begin
    addr_s = cnt_s[13:0];
    if (fetch_act_s) begin
      case (phase_s[2:1])
        2'd0:    addr_s = {2'b10, c_v_r, c_h_r, c_vt_r, c_ht_r};
        2'd1:    addr_s = {2'b10, c_v_r, c_h_r, 4'b1111, c_vt_r[4:2], c_ht_r[4:2]};
        2'd2:    addr_s = {1'b0, s_in, nt_byte_r, 1'b0, c_fv_r};
        2'd3:    addr_s = {1'b0, s_in, nt_byte_r, 1'b1, c_fv_r};
        default: addr_s = cnt_s[13:0];
      endcase
    end else begin
      addr_s = cnt_s[13:0];
    end
  end

  // Attribute quadrant select from coarse-Y bit 1 and coarse-X bit 1.
  always_comb begin
    case ({c_vt_r[1], c_ht_r[1]})
      2'b00:   at_sel_s = vram_d_in[1:0];
      2'b01:   at_sel_s = vram_d_in[3:2];
      2'b10:   at_sel_s = vram_d_in[5:4];
      2'b11:   at_sel_s = vram_d_in[7:6];
      default: at_sel_s = 2'd0;
    endcase
  end

  // Counters, fetch latches and tile outputs; a tile is delivered only after NT, AT, PT-lo in order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      c_fv_r      <= 3'd0;
      c_vt_r      <= 5'd0;
      c_v_r       <= 1'b0;
      c_h_r       <= 1'b0;
      c_ht_r      <= 5'd0;
      nt_byte_r   <= 8'd0;
      at_bits_r   <= 2'd0;
      pat_lo_r    <= 8'd0;
      fetch_r     <= F_IDLE;
      vram_a_r    <= 14'd0;
      bg_pat_lo_r <= 8'd0;
      bg_pat_hi_r <= 8'd0;
      bg_attr_r   <= 2'd0;
      tile_vld_r  <= 1'b0;
      rendering_r <= 1'b0;
    end else begin
      c_fv_r      <= fv_nxt_s;
      c_vt_r      <= vt_nxt_s;
      c_v_r       <= v_nxt_s;
      c_h_r       <= h_nxt_s;
      c_ht_r      <= ht_nxt_s;
      vram_a_r    <= addr_s;
      rendering_r <= render_s;
      tile_vld_r  <= 1'b0;
      if (pix_pulse_in && fetch_act_s) begin
        case (phase_s)
          3'd1: begin
            nt_byte_r <= vram_d_in;
            fetch_r   <= F_NT;
          end
          3'd3: begin
            at_bits_r <= at_sel_s;
            fetch_r   <= (fetch_r == F_NT) ? F_AT : F_IDLE;
          end
          3'd5: begin
            pat_lo_r <= vram_d_in;
            fetch_r  <= (fetch_r == F_AT) ? F_LO : F_IDLE;
          end
          3'd7: begin
            if (fetch_r == F_LO) begin
              bg_pat_lo_r <= pat_lo_r;
              bg_pat_hi_r <= vram_d_in;
              bg_attr_r   <= at_bits_r;
              tile_vld_r  <= 1'b1;
            end else begin
              tile_vld_r  <= 1'b0;
            end
            fetch_r <= F_IDLE;
          end
          default: fetch_r <= fetch_r;
        endcase
      end else if (!fetch_act_s) begin
        fetch_r <= F_IDLE;
      end else begin
        fetch_r <= fetch_r;
      end
    end
  end

  assign vram_a_out      = vram_a_r;
  assign bg_pat_lo_out   = bg_pat_lo_r;
  assign bg_pat_hi_out   = bg_pat_hi_r;
  assign bg_attr_out     = bg_attr_r;
  assign bg_tile_vld_out = tile_vld_r;
  assign rendering_out   = rendering_r;

endmodule
